// File: rtl/daphne_pulse_trigger_if.sv
// Event-record bus for daphne_pulse_trigger: one-entry record with valid/ready
// handshake plus the saturating dropped-event counter.
interface daphne_pulse_trigger_if #(
  parameter int unsigned SUM_W = 24
);
  logic                    ev_valid;
  logic                    ev_ready;
  logic signed [15:0]      ev_peak;
  logic        [7:0]       ev_peak_pos;
  logic        [7:0]       ev_len;
  logic signed [SUM_W-1:0] ev_sum;
  logic                    ev_trunc;
  logic        [15:0]      ev_dropped;

  modport master (
    output ev_valid, ev_peak, ev_peak_pos, ev_len, ev_sum, ev_trunc, ev_dropped,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_peak, ev_peak_pos, ev_len, ev_sum, ev_trunc, ev_dropped,
    output ev_ready
  );
endinterface

// File: rtl/daphne_pulse_trigger.sv
// Self-triggering pulse finder for the DAPHNE integrator output.
// Threshold crossing with hysteresis, peak/position/length/saturating-sum
// measurement, one-entry event record on a valid/ready bus.
// Optional baseline subtraction: define DAPHNE_TRIG_BASELINE_EN.
// The interface SUM_W parameter must match the module SUM_W.
module daphne_pulse_trigger #(
  parameter logic signed [15:0] THRESHOLD = 16'sd200,
  parameter logic signed [15:0] HYST      = 16'sd20,
  parameter int unsigned        MAX_LEN   = 255,
  parameter int unsigned        HOLDOFF   = 64,
  parameter int unsigned        SUM_W     = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic signed [15:0]            x,
  output logic                          trig,
  output logic                          busy,
  daphne_pulse_trigger_if.master        ev
);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

  localparam logic signed [16:0]    THR_LO  = {THRESHOLD[15], THRESHOLD} - {HYST[15], HYST};
  localparam logic signed [SUM_W:0] SUM_MAX = {2'b00, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] SUM_MIN = {2'b11, {(SUM_W-2){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic signed [15:0]      peak_q, peak_d;
  logic        [7:0]       pos_q, pos_d;
  logic        [7:0]       len_q, len_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic        [15:0]      hcnt_q, hcnt_d;
  logic                    trig_d, busy_d;
  logic                    evv_d, evtr_d;
  logic signed [15:0]      evpk_d;
  logic        [7:0]       evpos_d, evlen_d;
  logic signed [SUM_W-1:0] evsum_d;
  logic        [15:0]      evdrop_d;

  logic signed [15:0]      s;
  logic signed [16:0]      s_ext;
  logic signed [SUM_W:0]   sum_wide;
  logic                    end_pulse, end_trunc;

`ifdef DAPHNE_TRIG_BASELINE_EN
  logic signed [15:0] b_q;
  logic signed [16:0] diff;
  logic signed [16:0] diff_sh;

  // baseline-subtracted sample, saturated to 16 bits
  always_comb begin
    diff    = {x[15], x} - {b_q[15], b_q};
    diff_sh = diff >>> 4;
    if (diff > 17'sd32767)       s = 16'sh7FFF;
    else if (diff < -17'sd32768) s = 16'sh8000;
    else                         s = diff[15:0];
  end

  // baseline tracks slowly only while idle; the step stays within [b, x]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         b_q <= '0;
    else if (enable && state_q == ST_IDLE) b_q <= b_q + diff_sh[15:0];
  end
`else
  assign s = x;
`endif

  assign s_ext    = {s[15], s};
  assign sum_wide = $signed({sum_q[SUM_W-1], sum_q}) + $signed({{(SUM_W+1-16){s[15]}}, s});

  // next-state, measurement and record logic
  always_comb begin
    state_d   = state_q;
    peak_d    = peak_q;
    pos_d     = pos_q;
    len_d     = len_q;
    sum_d     = sum_q;
    hcnt_d    = hcnt_q;
    trig_d    = 1'b0;
    end_pulse = 1'b0;
    end_trunc = 1'b0;
    evv_d     = ev.ev_valid & ~ev.ev_ready;
    evpk_d    = ev.ev_peak;
    evpos_d   = ev.ev_peak_pos;
    evlen_d   = ev.ev_len;
    evsum_d   = ev.ev_sum;
    evtr_d    = ev.ev_trunc;
    evdrop_d  = ev.ev_dropped;

    case (state_q)
      ST_IDLE: begin
        if (enable && s >= THRESHOLD) begin
          state_d = ST_PULSE;
          peak_d  = s;
          pos_d   = '0;
          len_d   = 8'd1;
          sum_d   = {{(SUM_W-16){s[15]}}, s};
          trig_d  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (enable) begin
          if (s_ext < THR_LO) begin
            end_pulse = 1'b1;
          end else if (len_q == 8'(MAX_LEN)) begin
            end_pulse = 1'b1;
            end_trunc = 1'b1;
          end else begin
            len_d = len_q + 8'd1;
            if (sum_wide > SUM_MAX)      sum_d = SUM_MAX[SUM_W-1:0];
            else if (sum_wide < SUM_MIN) sum_d = SUM_MIN[SUM_W-1:0];
            else                         sum_d = sum_wide[SUM_W-1:0];
            if (s > peak_q) begin
              peak_d = s;
              pos_d  = len_q;
            end
          end
        end
      end
      ST_HOLD: begin
        if (enable) begin
          if (hcnt_q == 16'(HOLDOFF - 1)) state_d = ST_IDLE;
          else                            hcnt_d  = hcnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_pulse) begin
      if (!ev.ev_valid || ev.ev_ready) begin
        evv_d   = 1'b1;
        evpk_d  = peak_q;
        evpos_d = pos_q;
        evlen_d = len_q;
        evsum_d = sum_q;
        evtr_d  = end_trunc;
      end else if (ev.ev_dropped != 16'hFFFF) begin
        evdrop_d = ev.ev_dropped + 16'd1;
      end
      hcnt_d  = '0;
      state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // state and registered outputs; reset discards any partial pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      peak_q         <= '0;
      pos_q          <= '0;
      len_q          <= '0;
      sum_q          <= '0;
      hcnt_q         <= '0;
      trig           <= 1'b0;
      busy           <= 1'b0;
      ev.ev_valid    <= 1'b0;
      ev.ev_peak     <= '0;
      ev.ev_peak_pos <= '0;
      ev.ev_len      <= '0;
      ev.ev_sum      <= '0;
      ev.ev_trunc    <= 1'b0;
      ev.ev_dropped  <= '0;
    end else begin
      state_q        <= state_d;
      peak_q         <= peak_d;
      pos_q          <= pos_d;
      len_q          <= len_d;
      sum_q          <= sum_d;
      hcnt_q         <= hcnt_d;
      trig           <= trig_d;
      busy           <= busy_d;
      ev.ev_valid    <= evv_d;
      ev.ev_peak     <= evpk_d;
      ev.ev_peak_pos <= evpos_d;
      ev.ev_len      <= evlen_d;
      ev.ev_sum      <= evsum_d;
      ev.ev_trunc    <= evtr_d;
      ev.ev_dropped  <= evdrop_d;
    end
  end

endmodule

// File: tb/tb_daphne_pulse_trigger.sv
// Scoreboard bench for daphne_pulse_trigger (default build, baseline disabled).
`timescale 1ns/1ps
module tb_daphne_pulse_trigger;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic signed [15:0] x;
  logic               trig, busy;

  daphne_pulse_trigger_if #(.SUM_W(24)) bus ();

  daphne_pulse_trigger #(
    .THRESHOLD(16'sd200),
    .HYST(16'sd20),
    .MAX_LEN(255),
    .HOLDOFF(64),
    .SUM_W(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .x(x),
    .trig(trig),
    .busy(busy),
    .ev(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int peak;
    int pos;
    int len;
    int sum;
    int trunc;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input int peak, input int pos, input int len, input int sum, input int trunc);
    rec_t r;
    r.peak = peak; r.pos = pos; r.len = len; r.sum = sum; r.trunc = trunc;
    exp_q.push_back(r);
  endtask

  task automatic send(input int v);
    x = 16'(v);
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare whenever a record transfers
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_record: got peak %0d len %0d expected no record",
                 bus.ev_peak, bus.ev_len);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("ev_peak",     int'(bus.ev_peak),       e.peak);
        check("ev_peak_pos", int'(bus.ev_peak_pos),   e.pos);
        check("ev_len",      int'(bus.ev_len),        e.len);
        check("ev_sum",      int'($signed(bus.ev_sum)), e.sum);
        check("ev_trunc",    int'(bus.ev_trunc),      e.trunc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntrig;
    reset_n = 1'b0;
    enable = 1'b0;
    x = '0;
    bus.ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig",     int'(trig),           0);
    check("rst_busy",     int'(busy),           0);
    check("rst_ev_valid", int'(bus.ev_valid),   0);
    check("rst_dropped",  int'(bus.ev_dropped), 0);
    check("rst_len",      int'(bus.ev_len),     0);
    reset_n = 1'b1;
    bus.ev_ready = 1'b1;
    idle(2);

    // square pulse
    send_n(0, 10);
    send(300);
    check("sq_trig_rise", int'(trig), 1);
    check("sq_busy_rise", int'(busy), 1);
    send(300);
    check("sq_trig_once", int'(trig), 0);
    send_n(300, 3);
    expect_rec(300, 0, 5, 1500, 0);
    send(0);
    check("sq_ev_valid", int'(bus.ev_valid), 1);
    send(0);
    check("sq_ev_clear", int'(bus.ev_valid), 0);
    check("sq_busy_hold", int'(busy), 1);
    send_n(0, 70);
    check("sq_busy_idle", int'(busy), 0);

    // enable gap inside a pulse does not count toward len
    send(300);
    idle(3);
    send(300);
    expect_rec(300, 0, 2, 600, 0);
    send(0);
    send_n(0, 70);

    // hysteresis
    send(250); send(190); send(185);
    expect_rec(250, 0, 3, 625, 0);
    send(170);
    send_n(0, 70);

    // threshold and hysteresis boundaries
    send(199);
    check("thr_below", int'(trig), 0);
    send(200);
    check("thr_equal", int'(trig), 1);
    send(180);
    expect_rec(200, 0, 2, 380, 0);
    send(179);
    send_n(0, 70);

    // first-peak position with strict comparison
    send(210); send(300); send(300); send(250);
    expect_rec(300, 1, 4, 1060, 0);
    send(100);
    send_n(0, 70);

    // truncation and holdoff
    send(400);
    check("tr_trig", int'(trig), 1);
    send_n(400, 254);
    expect_rec(400, 0, 255, 102000, 1);
    send(400);
    check("tr_ev_valid", int'(bus.ev_valid), 1);
    ntrig = 0;
    for (int i = 0; i < 64; i++) begin
      send(400);
      if (trig === 1'b1) ntrig++;
    end
    check("tr_holdoff_notrig", ntrig, 0);
    send(400);
    check("tr_retrig", int'(trig), 1);
    expect_rec(400, 0, 1, 400, 0);
    send(0);
    send_n(0, 70);

    // back-pressure
    bus.ev_ready = 1'b0;
    send_n(300, 3);
    expect_rec(300, 0, 3, 900, 0);
    send(0);
    send_n(0, 70);
    send_n(250, 2);
    send(0);
    send(0);
    check("bp_dropped1", int'(bus.ev_dropped), 1);
    check("bp_peak_held", int'(bus.ev_peak), 300);
    send_n(0, 70);
    send(220);
    send(0);
    send(0);
    check("bp_dropped2", int'(bus.ev_dropped), 2);
    check("bp_len_held", int'(bus.ev_len), 3);
    check("bp_sum_held", int'($signed(bus.ev_sum)), 900);
    check("bp_valid_held", int'(bus.ev_valid), 1);
    send_n(0, 70);
    bus.ev_ready = 1'b1;
    idle(1);
    check("bp_valid_clear", int'(bus.ev_valid), 0);

    // asynchronous reset mid-pulse
    send_n(300, 3);
    check("mr_busy_before", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_busy",     int'(busy),           0);
    check("mr_valid",    int'(bus.ev_valid),   0);
    check("mr_dropped",  int'(bus.ev_dropped), 0);
    check("mr_trig",     int'(trig),           0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_n(0, 3);
    send(300);
    check("mr_retrig", int'(trig), 1);
    expect_rec(300, 0, 1, 300, 0);
    send(0);
    send_n(0, 5);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
